// File: rtl/sa_pkg.sv
// Shared types and default sizing for the switch-allocator output port.
package sa_pkg;

   localparam int DEF_DATA_W  = 32;
   localparam int DEF_DEPTH   = 4;
   localparam int DEF_CREDITS = 4;

   typedef logic [DEF_DATA_W-1:0] flit_t;
   typedef logic [1:0]            grant_t;

endpackage

// File: rtl/sa_sync_fifo.sv
// Synchronous FIFO with occupancy count; caller never pushes when full or pops when empty.
module sa_sync_fifo #(
   parameter int DATA_W = 32,
   parameter int DEPTH  = 4
) (
   input  logic                       clk,
   input  logic                       rst_n,
   input  logic                       push,
   input  logic [DATA_W-1:0]          din,
   input  logic                       pop,
   output logic [DATA_W-1:0]          dout,
   output logic [$clog2(DEPTH+1)-1:0] count
);

   localparam int PTR_W = $clog2(DEPTH);

   logic [DATA_W-1:0] mem [DEPTH];
   logic [PTR_W-1:0]  wr_ptr;
   logic [PTR_W-1:0]  rd_ptr;

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (push) wr_ptr <= wr_ptr + 1'b1;
         if (pop)  rd_ptr <= rd_ptr + 1'b1;
         case ({push, pop})
            2'b10:   count <= count + 1'b1;
            2'b01:   count <= count - 1'b1;
            default: count <= count;
         endcase
      end
   end

   // Storage is data only, so it is left out of reset.
   always_ff @(posedge clk) begin
      if (push) mem[wr_ptr] <= din;
   end

   assign dout = mem[rd_ptr];

endmodule

// File: rtl/sa_out_port.sv
// Output port behind the 2x2 switch allocator: grant mux, FIFO, credit-gated output register.
// Optional sticky protocol-error flag and assertion enabled by SA_OUT_PORT_ERR_EN.
module sa_out_port
   import sa_pkg::*;
#(
   parameter int DATA_W  = DEF_DATA_W,
   parameter int DEPTH   = DEF_DEPTH,
   parameter int CREDITS = DEF_CREDITS
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              req0,
   input  grant_t            grant,
   input  logic [DATA_W-1:0] din0,
   input  logic [DATA_W-1:0] din1,
   output logic              ack,
   output logic              out_valid,
   output logic [DATA_W-1:0] out_data,
   input  logic              out_credit,
   output logic              busy
`ifdef SA_OUT_PORT_ERR_EN
   ,
   output logic              err
`endif
);

   localparam int CNT_W = $clog2(DEPTH+1);
   localparam int CRD_W = $clog2(CREDITS+1);

   logic [CNT_W-1:0]  count;
   logic [CRD_W-1:0]  credit_cnt;
   logic [DATA_W-1:0] fifo_dout;
   logic [DATA_W-1:0] din_sel;
   logic              push;
   logic              pop;

   // ack depends on registers and rst_n only, never on grant, to keep the allocator loop open.
   assign ack     = rst_n & (count < CNT_W'(DEPTH));
   assign push    = ack & (grant != 2'b00);
   assign din_sel = grant[0] ? din0 : din1;
   assign pop     = (count != '0) & (credit_cnt != '0);
   assign busy    = (count != '0) | req0;

   sa_sync_fifo #(
      .DATA_W (DATA_W),
      .DEPTH  (DEPTH)
   ) u_fifo (
      .clk   (clk),
      .rst_n (rst_n),
      .push  (push),
      .din   (din_sel),
      .pop   (pop),
      .dout  (fifo_dout),
      .count (count)
   );

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         out_valid <= 1'b0;
         out_data  <= '0;
      end else begin
         out_valid <= pop;
         if (pop) out_data <= fifo_dout;
      end
   end

   // A send and a return in the same cycle cancel; returns beyond CREDITS are dropped.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         credit_cnt <= CRD_W'(CREDITS);
      end else begin
         case ({pop, out_credit})
            2'b10:   credit_cnt <= credit_cnt - 1'b1;
            2'b01:   if (credit_cnt != CRD_W'(CREDITS)) credit_cnt <= credit_cnt + 1'b1;
            default: credit_cnt <= credit_cnt;
         endcase
      end
   end

`ifdef SA_OUT_PORT_ERR_EN
   logic err_evt;

   assign err_evt = (grant == 2'b11)
                  | ((grant != 2'b00) & ~ack)
                  | (out_credit & (credit_cnt == CRD_W'(CREDITS)));

   always_ff @(posedge clk) begin
      if (!rst_n)       err <= 1'b0;
      else if (err_evt) err <= 1'b1;
   end

   a_no_protocol_err: assert property (@(posedge clk) disable iff (!rst_n) !err_evt)
      else $warning("sa_out_port: illegal grant or credit event");
`endif

endmodule

// File: tb/tb_sa_out_port.sv
// Randomized bench for sa_out_port with a count/queue reference model and a scoreboard monitor.
module tb_sa_out_port;

   localparam int DW  = 32;
   localparam int DEP = 4;
   localparam int CRD = 4;

   logic          clk = 1'b0;
   logic          rst_n = 1'b0;
   logic          req0 = 1'b0;
   logic [1:0]    grant = 2'b00;
   logic [DW-1:0] din0 = '0;
   logic [DW-1:0] din1 = '0;
   logic          ack;
   logic          out_valid;
   logic [DW-1:0] out_data;
   logic          out_credit = 1'b0;
   logic          busy;
`ifdef SA_OUT_PORT_ERR_EN
   logic          err;
`endif

   sa_out_port #(.DATA_W(DW), .DEPTH(DEP), .CREDITS(CRD)) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .req0       (req0),
      .grant      (grant),
      .din0       (din0),
      .din1       (din1),
      .ack        (ack),
      .out_valid  (out_valid),
      .out_data   (out_data),
      .out_credit (out_credit),
      .busy       (busy)
`ifdef SA_OUT_PORT_ERR_EN
      ,
      .err        (err)
`endif
   );

   always #5 clk = ~clk;

   int            n_checks = 0;
   int            n_fail   = 0;
   bit            started  = 0;
   int            m_cnt    = 0;
   int            m_cred   = CRD;
   bit            exp_valid = 0;
   bit            exp_err   = 0;
   logic [DW-1:0] sb[$];

   task automatic check(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   // Scoreboard monitor: every presented flit must match the oldest accepted flit.
   always @(negedge clk) begin
      if (started) begin
         check("out_valid", DW'(out_valid), DW'(exp_valid));
         if (out_valid === 1'b1) begin
            if (sb.size() == 0) begin
               n_checks++;
               n_fail++;
               $display("FAIL out_data: got %0h expected none (scoreboard empty)", out_data);
            end else begin
               check("out_data", out_data, sb.pop_front());
            end
         end
      end
   end

   // One clock cycle: drive inputs, check combinational outputs, then advance the model at the edge.
   task automatic step(input bit rst, input logic [1:0] g, input logic [DW-1:0] d0,
                       input logic [DW-1:0] d1, input bit cr, input bit rq);
      bit m_ack;
      bit m_pop;
      rst_n      = ~rst;
      grant      = g;
      din0       = d0;
      din1       = d1;
      out_credit = cr;
      req0       = rq;
      @(negedge clk);
      m_ack = !rst && (m_cnt < DEP);
      if (started) begin
         check("ack", DW'(ack), DW'(m_ack));
         check("busy", DW'(busy), DW'((m_cnt != 0) || rq));
`ifdef SA_OUT_PORT_ERR_EN
         check("err", DW'(err), DW'(exp_err));
`endif
      end
      @(posedge clk);
      if (rst) begin
         m_cnt     = 0;
         m_cred    = CRD;
         exp_valid = 0;
         exp_err   = 0;
         sb.delete();
         started   = 1;
      end else begin
         m_pop = (m_cnt > 0) && (m_cred > 0);
         if (g == 2'b11 || (g != 2'b00 && !m_ack) || (cr && m_cred == CRD)) exp_err = 1;
         m_cred = m_cred - int'(m_pop) + int'(cr);
         if (m_cred > CRD) m_cred = CRD;
         if (m_ack && g != 2'b00) begin
            sb.push_back(g[0] ? d0 : d1);
            m_cnt++;
         end
         if (m_pop) m_cnt--;
         exp_valid = m_pop;
      end
      #1;
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) step(0, 2'b00, '0, '0, 0, 0);
   endtask

   initial begin
      // reset and idle
      step(1, 2'b00, '0, '0, 0, 0);
      step(1, 2'b00, '0, '0, 0, 0);
      idle(2);

      // single flit, two-cycle latency
      step(0, 2'b01, 32'hA5, 32'h0, 0, 1);
      idle(3);
      step(0, 2'b00, '0, '0, 1, 0);

      // no credit returns, grant every cycle until full
      for (int i = 0; i < 10; i++) step(0, 2'b01, DW'(i + 16), '0, 0, 1);
      idle(2);

      // one credit released from the full/zero-credit state
      step(0, 2'b00, '0, '0, 1, 1);
      idle(3);
      for (int i = 0; i < 4; i++) step(0, 2'b00, '0, '0, 1, 0);
      idle(6);

      // alternate inputs, order must be preserved
      step(1, 2'b00, '0, '0, 0, 0);
      for (int i = 0; i < 4; i++)
         step(0, (i % 2 == 0) ? 2'b01 : 2'b10, DW'(1 + i / 2), DW'(100 + i / 2), 0, 1);
      idle(6);

      // illegal double grant, saturating credit return, reset mid-stream
      step(1, 2'b00, '0, '0, 0, 0);
      step(0, 2'b11, 32'h11, 32'h22, 0, 1);
      idle(3);
      step(0, 2'b00, '0, '0, 1, 0);
      idle(2);
      for (int i = 0; i < 3; i++) step(0, 2'b10, '0, DW'(32'h300 + i), 0, 1);
      step(1, 2'b00, '0, '0, 0, 0);
      idle(4);

      // randomized traffic with occasional resets and illegal events
      for (int i = 0; i < 3000; i++) begin
         int r;
         logic [1:0] g;
         r = int'($urandom_range(0, 7));
         g = (r < 3) ? 2'b00 : (r < 5) ? 2'b01 : (r < 7) ? 2'b10 : 2'b11;
         step(($urandom_range(0, 99) == 0), g, DW'($urandom), DW'($urandom),
              ($urandom_range(0, 2) == 0), (g != 2'b00) || ($urandom_range(0, 3) == 0));
      end
      for (int i = 0; i < 8; i++) step(0, 2'b00, '0, '0, 1, 0);
      idle(4);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
